sr_pulse_debouncer: RTL
=======================

// Module: sr_pulse_debouncer
// PURPOSE
//   Front end that drives the s/r inputs of the SR flip-flop stage.
//   - Takes two raw, asynchronous push-button levels (set, clear).
//   - Synchronises and debounces each one.
//   - Turns each clean press into a single-cycle s or r command pulse.
//   - Never asserts s and r together, so the forbidden S=R=1 input can never reach the flop.
// PARAMETERS
//   DB_CYCLES  4  consecutive equal synchronised samples needed to accept a level change (>=1)
//   CNT_W      8  debounce counter width; must satisfy 2**CNT_W > DB_CYCLES
// PORTS
//   clock     in   1  single system clock, rising edge
//   reset     in   1  synchronous, active-high reset
//   set_btn   in   1  raw set button level, asynchronous, may bounce
//   clr_btn   in   1  raw clear button level, asynchronous, may bounce
//   s         out  1  one-cycle set command to the SR flip-flop
//   r         out  1  one-cycle reset command to the SR flip-flop
//   set_held  out  1  debounced set level (high in PRESSED or FALL_WAIT)
//   clr_held  out  1  debounced clear level (high in PRESSED or FALL_WAIT)
//   conflict  out  1  one-cycle flag: both presses were accepted on the same edge
// BEHAVIOUR
//   Reset
//     - Sync flops = 0, both channel FSMs = IDLE, counters = 0.
//     - s, r, set_held, clr_held, conflict all = 0.
//     - All outputs are registered.
//   Synchroniser
//     - Two-flop chain per input; the FSM samples the second flop only.
//   Channel FSM (identical, independent per channel)
//     IDLE       sample=1 -> RISE_WAIT, cnt=1 (DB_CYCLES=1: go straight to PRESSED + event)
//     RISE_WAIT  sample=1: cnt+1; when cnt reaches DB_CYCLES -> PRESSED, press event, cnt=0
//                sample=0 -> IDLE, cnt=0 (bounce rejected, no event)
//     PRESSED    sample=0 -> FALL_WAIT, cnt=1; sample=1 -> stay (no auto-repeat)
//     FALL_WAIT  sample=0: cnt+1; when cnt reaches DB_CYCLES -> IDLE, cnt=0, no event
//                sample=1 -> PRESSED, cnt=0
//     - A new event requires a full debounced release followed by a new press.
//   Latency
//     - Raw input goes high and stays high; call the first edge that samples it edge 0.
//     - The event is registered at edge DB_CYCLES+1.
//     - So s/r is high in the cycle after edge DB_CYCLES+1 (default: after edge 5).
//   Arbitration (registered outputs)
//     - s <= set_evt & ~clr_evt
//     - r <= clr_evt & ~set_evt
//     - conflict <= set_evt & clr_evt; s and r both stay 0 that cycle.
//     - s & r == 1 never occurs.
//   Boundaries
//     - Bouncing shorter than DB_CYCLES samples produces no pulse.
//     - Counter never exceeds DB_CYCLES.
//     - Reset mid-debounce or mid-hold returns to IDLE.
//     - A button still held after reset falls is debounced again and produces one pulse.
//   Simultaneous events
//     - A press on one channel while the other is held is legal and gives a normal pulse.
// TESTING (clock period 20 ns)
//   1. reset=1 for 3 cycles, buttons at 0 -> all outputs 0; no pulses for 10 further cycles.
//   2. set_btn 0->1 held 10 cycles, DB_CYCLES=4 -> s=1 for exactly 1 cycle after edge 5;
//      r=0 throughout; set_held=1 from that same edge.
//   3. clr_btn toggles 1,0,1,1,0 (3-cycle highs max) -> r stays 0, clr_held stays 0.
//   4. set_btn and clr_btn rise on the same edge, held -> conflict=1 for 1 cycle; s=r=0.
//   5. Hold set_btn for 20 cycles, release for 6 cycles, press again -> exactly two s pulses.
//   6. Assert reset at cycle 3 of RISE_WAIT, set_btn still high -> no pulse during reset;
//      after release, s pulses once, DB_CYCLES+2 edges after reset falls.

Source files
------------

// File: rtl/sr_pulse_debouncer_if.sv
// Button inputs and SR command outputs of the pulse debouncer.
// The slave side is the debouncer. The master side drives the buttons and watches the commands.
interface sr_pulse_debouncer_if;
    logic set_btn;
    logic clr_btn;
    logic s;
    logic r;
    logic set_held;
    logic clr_held;
    logic conflict;

    modport master (
        output set_btn, clr_btn,
        input  s, r, set_held, clr_held, conflict
    );

    modport slave (
        input  set_btn, clr_btn,
        output s, r, set_held, clr_held, conflict
    );
endinterface

// File: rtl/sr_pulse_debouncer.sv
// Purpose: synchronise and debounce two raw buttons, then emit exclusive one-cycle s/r pulses.
// Latency: a stable press gives its pulse in the cycle after edge DB_CYCLES+1 (edge 0 first samples it). There is no backpressure.

module sr_pulse_debouncer_chan #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_evt,
    output logic o_held_nxt
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RISE_WAIT = 2'd1,
        PRESSED   = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_evt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_cnt_inc = r_cnt + CNT_ONE;

    // The counter holds the number of agreeing samples seen so far. It is cleared whenever the FSM settles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_evt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    if (DB_CYCLES == 1) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_evt       = 1'b1;
                    end else begin
                        w_state_nxt = RISE_WAIT;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            RISE_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == DB_LIM) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_evt       = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    if (DB_CYCLES == 1) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = FALL_WAIT;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            FALL_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == DB_LIM) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_evt      = w_evt;
    assign o_held_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == FALL_WAIT);
endmodule

module sr_pulse_debouncer #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    sr_pulse_debouncer_if.slave       io_bus
);
    logic w_set_evt;
    logic w_clr_evt;
    logic w_set_held_nxt;
    logic w_clr_held_nxt;
    logic r_s;
    logic r_r;
    logic r_conflict;
    logic r_set_held;
    logic r_clr_held;

    sr_pulse_debouncer_chan #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_set_chan (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_btn      (io_bus.set_btn),
        .o_evt      (w_set_evt),
        .o_held_nxt (w_set_held_nxt)
    );

    sr_pulse_debouncer_chan #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_clr_chan (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_btn      (io_bus.clr_btn),
        .o_evt      (w_clr_evt),
        .o_held_nxt (w_clr_held_nxt)
    );

    // Presses accepted on the same edge cancel each other, so the flop never sees S=R=1.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
            r_set_held <= 1'b0;
            r_clr_held <= 1'b0;
        end else begin
            r_s        <= w_set_evt & ~w_clr_evt;
            r_r        <= w_clr_evt & ~w_set_evt;
            r_conflict <= w_set_evt & w_clr_evt;
            r_set_held <= w_set_held_nxt;
            r_clr_held <= w_clr_held_nxt;
        end
    end

    assign io_bus.s        = r_s;
    assign io_bus.r        = r_r;
    assign io_bus.conflict = r_conflict;
    assign io_bus.set_held = r_set_held;
    assign io_bus.clr_held = r_clr_held;
endmodule
